// File: rtl/clock_period_meter.sv
// clock_period_meter
//   Measures a slow clock or tick input (sig_i) in units of clk_i cycles.
//   Each completed sig_i cycle (rising edge to rising edge) produces a
//   period and high-time measurement together with a one-cycle valid strobe.
//   A missing rising edge for TIMEOUT cycles is flagged as a stall.
//
// Parameters
//   W        width of the cycle counter and of the measurement outputs
//   TIMEOUT  cycles without a sig_i rising edge before a stall is declared
//            (3 .. 2^W-1, so the counter never wraps before reaching it)
//
// Ports
//   clk_i      in   system clock
//   rst_i      in   asynchronous reset, active high
//   en_i       in   measurement enable (clk_i domain)
//   sig_i      in   signal under test, asynchronous to clk_i
//   period_o   out  clk_i cycles between the last two sig_i rising edges
//   high_o     out  clk_i cycles sig_i was high in the last completed period
//   valid_o    out  one-cycle pulse when period_o/high_o update
//   timeout_o  out  level, no rising edge seen for TIMEOUT cycles
//   locked_o   out  level, at least one valid measurement since (re)arm

module clock_period_meter #(
  parameter int unsigned W       = 32,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         sig_i,
  output logic [W-1:0] period_o,
  output logic [W-1:0] high_o,
  output logic         valid_o,
  output logic         timeout_o,
  output logic         locked_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    MEASURE   = 2'd2
  } state_t;

  localparam logic [W-1:0] TIMEOUT_C = W'(TIMEOUT);
  localparam logic [W-1:0] CNT_MAX   = '1;
  localparam logic [W-1:0] CNT_ONE   = W'(1);

  state_t       state;
  logic         s1, s2, s3;
  logic [W-1:0] cnt;
  logic [W-1:0] hi_tmp;
  logic         rise;
  logic         fall;

  // s1/s2 resolve metastability; s3 is the previous synchronized value used
  // for edge detection. rise and fall can never be true together.
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  // NOTE: every register here is updated with <= so all of them sample the
  // values from before the edge; blocking assignments would let later
  // statements see half-updated state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
      cnt       <= '0;
      hi_tmp    <= '0;
      period_o  <= '0;
      high_o    <= '0;
      valid_o   <= 1'b0;
      timeout_o <= 1'b0;
      locked_o  <= 1'b0;
    end else begin
      s1 <= sig_i;
      s2 <= s1;
      s3 <= s2;

      // valid_o is a strobe: low unless a measurement completes this cycle.
      valid_o <= 1'b0;

      if (!en_i) begin
        // Disable wins over everything; measurements hold their last value.
        state     <= IDLE;
        cnt       <= '0;
        locked_o  <= 1'b0;
        timeout_o <= 1'b0;
      end else begin
        // Cycle counter: restarts at 1 on the rise cycle so that the value
        // seen on the next rise equals the period; saturates, never wraps.
        if (state == IDLE) begin
          cnt <= '0;
        end else if (rise) begin
          cnt <= CNT_ONE;
        end else if (cnt != CNT_MAX) begin
          cnt <= cnt + CNT_ONE;
        end

        // High time is captured at the fall, relative to the last rise.
        if (state == MEASURE && fall) begin
          hi_tmp <= cnt;
        end

        case (state)
          IDLE: begin
            locked_o  <= 1'b0;
            timeout_o <= 1'b0;
            state     <= WAIT_EDGE;
          end

          WAIT_EDGE: begin
            // The first rise only arms the meter; a stall takes priority.
            if (cnt == TIMEOUT_C) begin
              timeout_o <= 1'b1;
            end else if (rise) begin
              state <= MEASURE;
            end
          end

          MEASURE: begin
            if (cnt == TIMEOUT_C) begin
              state     <= WAIT_EDGE;
              timeout_o <= 1'b1;
              locked_o  <= 1'b0;
            end else if (rise) begin
              period_o  <= cnt;
              high_o    <= hi_tmp;
              valid_o   <= 1'b1;
              locked_o  <= 1'b1;
              timeout_o <= 1'b0;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clock_period_meter.sv
// Self-checking bench for clock_period_meter.
//   dut    : TIMEOUT = 1000, used for the measurement, enable and reset tests
//   dut_to : TIMEOUT = 50,   used for the stall / recovery test
// sig_i is driven on the falling edge of clk_i, outputs are sampled there too.

module tb_clock_period_meter;

  localparam int W = 32;
  localparam int TO_SHORT = 50;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         en_i  = 1'b0;
  logic         sig_i = 1'b0;

  logic [W-1:0] period_o, high_o;
  logic         valid_o, timeout_o, locked_o;
  logic [W-1:0] period_t, high_t;
  logic         valid_t, timeout_t, locked_t;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  clock_period_meter #(.W(W), .TIMEOUT(1000)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (en_i),
    .sig_i     (sig_i),
    .period_o  (period_o),
    .high_o    (high_o),
    .valid_o   (valid_o),
    .timeout_o (timeout_o),
    .locked_o  (locked_o)
  );

  clock_period_meter #(.W(W), .TIMEOUT(TO_SHORT)) dut_to (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (en_i),
    .sig_i     (sig_i),
    .period_o  (period_t),
    .high_o    (high_t),
    .valid_o   (valid_t),
    .timeout_o (timeout_t),
    .locked_o  (locked_t)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model for random stimulus: works on sample timestamps only.
  // A rising sample at edge r closes the period started at the previous
  // rising sample; the result must appear as valid_o after edge r+2.
  // ---------------------------------------------------------------------
  typedef struct {
    int due;   // value of ecount at the negedge where valid_o is expected
    int per;
    int hi;
  } exp_t;

  exp_t q[$];
  int   ecount    = 0;
  bit   model_on  = 1'b0;
  bit   armed     = 1'b0;
  logic prev_s    = 1'b0;
  int   last_rise = 0;
  int   last_high = 0;

  always @(posedge clk_i) begin
    if (model_on) begin
      if (sig_i && !prev_s) begin
        if (armed) q.push_back('{ecount + 3, ecount - last_rise, last_high});
        armed     = 1'b1;
        last_rise = ecount;
      end else if (!sig_i && prev_s && armed) begin
        last_high = ecount - last_rise;
      end
      prev_s = sig_i;
    end
    ecount++;
  end

  task automatic model_check();
    bit   exp_v;
    exp_t e;
    exp_v = (q.size() > 0) && (q[0].due == ecount);
    check("rand_valid", 32'(valid_o), 32'(exp_v));
    if (exp_v) begin
      e = q.pop_front();
      check("rand_period", period_o, 32'(e.per));
      check("rand_high", high_o, 32'(e.hi));
    end
  endtask

  // ---------------------------------------------------------------------
  // Directed helpers
  // ---------------------------------------------------------------------
  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    en_i  = 1'b0;
    sig_i = 1'b0;
    @(negedge clk_i);
    check("rst_period", period_o, 0);
    check("rst_high", high_o, 0);
    check("rst_valid", 32'(valid_o), 0);
    check("rst_timeout", 32'(timeout_o), 0);
    check("rst_locked", 32'(locked_o), 0);
    check("rst_locked_to", 32'(locked_t), 0);
    rst_i = 1'b0;
    en_i  = 1'b1;
    repeat (4) @(negedge clk_i);
  endtask

  typedef struct {
    int           p;      // sig_i period in clk_i cycles
    int           h;      // sig_i high cycles
    int           np;     // periods to drive
    logic [W-1:0] exp_p;  // expected period_o
    logic [W-1:0] exp_h;  // expected high_o
  } vec_t;

  // Drives np periods starting high at iteration 0. The arming rise gives no
  // strobe; each later rise sampled at iteration i gives valid_o at i+3.
  task automatic run_wave_check(input vec_t v, input string tag);
    bit exp_v;
    for (int j = 0; j <= v.np * v.p + 2; j++) begin
      @(negedge clk_i);
      exp_v = (j >= 3 + v.p) && ((j - 3) % v.p == 0);
      check({tag, "_valid"}, 32'(valid_o), 32'(exp_v));
      if (j == 3) check({tag, "_locked_arm"}, 32'(locked_o), 0);
      if (exp_v) begin
        check({tag, "_period"}, period_o, v.exp_p);
        check({tag, "_high"}, high_o, v.exp_h);
        check({tag, "_locked"}, 32'(locked_o), 1);
        check({tag, "_timeout"}, 32'(timeout_o), 0);
      end
      sig_i = ((j % v.p) < v.h);
    end
  endtask

  vec_t vecs[4];
  vec_t v10;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{100, 50, 3, 100, 50};
    vecs[1] = '{7,   2,  4, 7,   2};
    vecs[2] = '{2,   1,  6, 2,   1};
    vecs[3] = '{13,  12, 3, 13,  12};
    v10     = '{10,  4,  3, 10,  4};

    // Table of square waves, each after a fresh reset.
    foreach (vecs[i]) begin
      do_reset();
      run_wave_check(vecs[i], $sformatf("wave%0d", i));
    end

    // Enable drop mid-period, then re-arm.
    do_reset();
    run_wave_check(v10, "en_pre");
    en_i = 1'b0;  // takes effect at the edge where the last rise is detected
    for (int k = 0; k < 15; k++) begin
      @(negedge clk_i);
      check("en_off_valid", 32'(valid_o), 0);
      check("en_off_locked", 32'(locked_o), 0);
      check("en_off_period", period_o, 10);
      check("en_off_high", high_o, 4);
      sig_i = (((33 + k) % 10) < 4);
    end
    sig_i = 1'b0;
    repeat (4) @(negedge clk_i);
    en_i = 1'b1;
    repeat (2) @(negedge clk_i);
    v10.np = 2;
    run_wave_check(v10, "en_rearm");

    // Asynchronous reset between edges.
    do_reset();
    v10.np = 3;
    run_wave_check(v10, "ar_pre");
    #2 rst_i = 1'b1;
    #1;
    check("ar_period", period_o, 0);
    check("ar_high", high_o, 0);
    check("ar_valid", 32'(valid_o), 0);
    check("ar_locked", 32'(locked_o), 0);
    check("ar_timeout", 32'(timeout_o), 0);
    sig_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    v10.np = 2;
    run_wave_check(v10, "ar_post");

    // Stall detection on dut_to (TIMEOUT = 50), period 20 / high 5.
    do_reset();
    for (int j = 0; j <= 62; j++) begin
      @(negedge clk_i);
      sig_i = ((j % 20) < 5);
    end
    check("to_lock_locked", 32'(locked_t), 1);
    check("to_lock_period", period_t, 20);
    // Last rise sampled at 60: timeout_o appears at iteration 60+3+TIMEOUT.
    for (int j = 63; j <= 130; j++) begin
      @(negedge clk_i);
      sig_i = 1'b0;
      check("to_level", 32'(timeout_t), 32'(j >= 63 + TO_SHORT));
      if (j == 63 + TO_SHORT) begin
        check("to_locked", 32'(locked_t), 0);
        check("to_period_hold", period_t, 20);
        check("to_high_hold", high_t, 5);
      end
    end
    // Resume: two rises needed before lock returns.
    for (int j = 0; j <= 23; j++) begin
      @(negedge clk_i);
      if (j == 3) check("to_arm_valid", 32'(valid_t), 0);
      if (j == 22) begin
        check("to_pre_timeout", 32'(timeout_t), 1);
        check("to_pre_locked", 32'(locked_t), 0);
      end
      if (j == 23) begin
        check("to_res_valid", 32'(valid_t), 1);
        check("to_res_timeout", 32'(timeout_t), 0);
        check("to_res_locked", 32'(locked_t), 1);
        check("to_res_period", period_t, 20);
        check("to_res_high", high_t, 5);
      end
      sig_i = ((j % 20) < 5);
    end

    // Random square-wave segments against the timestamp model.
    do_reset();
    prev_s    = 1'b0;
    armed     = 1'b0;
    last_rise = 0;
    last_high = 0;
    q.delete();
    model_on  = 1'b1;
    for (int s = 0; s < 12; s++) begin
      int p, h, n;
      p = $urandom_range(40, 2);
      h = $urandom_range(p - 1, 1);
      n = $urandom_range(4, 2);
      for (int i = 0; i < p * n; i++) begin
        @(negedge clk_i);
        model_check();
        sig_i = ((i % p) < h);
      end
    end
    sig_i = 1'b0;
    repeat (6) begin
      @(negedge clk_i);
      model_check();
    end
    check("rand_drain", 32'(q.size()), 0);
    model_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
